alu_sync: RTL and testbench
===========================

Name: alu_sync

Overview:
- Registered, parameterizable integer ALU: add, sub, and, or, xor, sll, srl, sra on two WIDTH-bit operands.
- Produces result plus carry, overflow, zero and negative flags.
- Sits in the execute stage; one-cycle latency with a valid qualifier so upstream and downstream stages can pipeline through it.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  a, b and op are valid this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; also the shift amount for shift ops
- op  in  3  operation select
- out_valid  out  1  registered outputs hold a new result
- y  out  WIDTH  result
- carry  out  1  carry-out (ADD) or borrow (SUB)
- overflow  out  1  signed two's-complement overflow
- zero  out  1  y equals 0
- negative  out  1  y[WIDTH-1]

Behaviour:
- Op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- Reset: while rst_n=0, all outputs are 0, including y, all flags and out_valid. Reset asserts asynchronously and releases synchronously to clk.
- Latency: when in_valid=1 at a rising edge, y and all flags show the result of that cycle's a/b/op after the edge, and out_valid=1.
- When in_valid=0 at an edge, out_valid goes 0 and y and all flags hold their previous values.
- Back-to-back valid inputs give one result per cycle. There is no backpressure.
- ADD: t = {0,a} + {0,b} (WIDTH+1 bits).
  - y = t[WIDTH-1:0]; carry = t[WIDTH].
  - overflow = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]).
- SUB: t = {0,a} - {0,b} (WIDTH+1 bits, modulo 2^(WIDTH+1)).
  - y = t[WIDTH-1:0]; carry = t[WIDTH], so carry=1 exactly when a < b unsigned (borrow).
  - overflow = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]).
- AND/OR/XOR: bitwise result; carry=0, overflow=0.
- Shifts: the full WIDTH-bit b, unsigned, is the amount. If b >= WIDTH, the amount saturates to WIDTH-1; otherwise the amount is b.
  - SLL fills with 0 from the right.
  - SRL fills with 0 from the left.
  - SRA replicates a[MSB].
  - carry=0, overflow=0.
- zero = (y == 0) and negative = y[WIDTH-1], computed from the result for every op.
- Only one op per valid cycle; op is fully decoded, so no illegal codes exist.

Decomposition:
- Package alu_pkg: op encoding constants/enum (OP_ADD .. OP_SRA) and a flags struct {carry, overflow, zero, negative}.
- Sub-module alu_datapath: purely combinational. Computes y and the four flags from a, b and op.
- alu_sync instantiates alu_datapath and adds the output register stage, the valid pipeline and reset.

Test Plan:
- WIDTH=8: ADD a=255, b=1 -> next cycle y=0, carry=1, overflow=0, zero=1, negative=0. ADD 127+1 -> y=128, carry=0, overflow=1, negative=1.
- SUB 0-1 -> y=255, carry=1, overflow=0, negative=1. SUB 128-1 -> y=127, carry=0, overflow=1. SUB 5-3 -> y=2, all flags 0.
- Logic: AND 0xFF,0x00 -> y=0, zero=1. OR 0xFF,0x00 -> y=0xFF, negative=1. XOR 0xFF,0xFF -> y=0, zero=1; carry and overflow 0 throughout.
- Shifts with a=1 (SLL) or a=0x80 (SRL/SRA), b in {0, 1, 7, 8, 9}:
  - SLL 1 -> 1, 2, 128, 128, 128.
  - SRL 0x80 -> 128, 64, 1, 1, 1.
  - SRA 0x80 -> 0x80, 0xC0, 0xFF, 0xFF, 0xFF.
  - SRA with a=0 -> 0 for every b.
- Pipeline and handshake:
  - Valid inputs on 3 consecutive cycles -> 3 consecutive results with out_valid=1.
  - in_valid=0 -> out_valid=0 and y/flags unchanged.
  - rst_n asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
  - First valid input after release -> its result appears one cycle later.
- Randomized: 500+ random a/b/op vectors at WIDTH=8 and WIDTH=16, checked against a golden model implementing the rules above.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encoding and flag bundle shared by the ALU files.
// Ops: ADD SUB AND OR XOR SLL SRL SRA; flags: carry overflow zero negative.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: combinational result and flags from a_i, b_i, op_i.
// Ports: a_i/b_i operands, op_i select, y_o result, flags_o flag bundle.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] y_o,
  output alu_flags_t       flags_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);
  localparam logic [SW-1:0] SMAX = SW'(WIDTH - 1);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  dif;
  logic [SW-1:0]   sh;
  logic            c;
  logic            ov;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    dif = {1'b0, a_i} - {1'b0, b_i};
    // amounts past the top bit clamp to WIDTH-1
    sh  = (b_i >= W_L) ? SMAX : b_i[SW-1:0];
    y_o = '0;
    c   = 1'b0;
    ov  = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        y_o = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        ov  = (a_i[MSB] == b_i[MSB]) &&
              (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        y_o = dif[WIDTH-1:0];
        c   = dif[WIDTH];
        ov  = (a_i[MSB] != b_i[MSB]) &&
              (dif[MSB] != a_i[MSB]);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_SLL: y_o = a_i << sh;
      OP_SRL: y_o = a_i >> sh;
      OP_SRA: y_o = $signed(a_i) >>> sh;
    endcase
    flags_o.carry    = c;
    flags_o.overflow = ov;
    flags_o.zero     = ~|y_o;
    flags_o.negative = y_o[MSB];
  end

endmodule

// File: rtl/alu_sync.sv
// alu_sync: registered ALU, one-cycle latency, valid-qualified outputs.
// Ports: clk, rst_n, in_valid/a/b/op in; out_valid/y/carry/overflow/zero/negative out.
module alu_sync
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] dp_y;
  alu_flags_t       dp_f;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] y_d, y_q;
  alu_flags_t       flags_d, flags_q;

  alu_datapath #(.WIDTH(WIDTH)) u_dp (
    .a_i     (a),
    .b_i     (b),
    .op_i    (alu_op_e'(op)),
    .y_o     (dp_y),
    .flags_o (dp_f)
  );

  // result and flags hold across idle cycles
  always_comb begin
    valid_d = in_valid;
    y_d     = y_q;
    flags_d = flags_q;
    if (in_valid) begin
      y_d     = dp_y;
      flags_d = dp_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_sync.sv
// tb_alu_sync: directed and randomized checks of alu_sync at WIDTH 8 and 16.
// Outputs packed as {out_valid, carry, overflow, zero, negative, y}.
module tb_alu_sync;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v8, ov8_v, c8, o8, z8, n8;
  logic [7:0] a8, b8, y8;
  logic [2:0] op8;

  logic        v16, ov16_v, c16, o16, z16, n16;
  logic [15:0] a16, b16, y16;
  logic [2:0]  op16;

  alu_sync #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .a(a8), .b(b8), .op(op8),
    .out_valid(ov8_v), .y(y8), .carry(c8),
    .overflow(o8), .zero(z8), .negative(n8)
  );

  alu_sync #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16),
    .a(a16), .b(b16), .op(op16),
    .out_valid(ov16_v), .y(y16), .carry(c16),
    .overflow(o16), .zero(z16), .negative(n16)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] e8 = '0;
  logic [63:0] e16 = '0;

  function automatic logic [63:0] obs8();
    return {51'b0, ov8_v, c8, o8, z8, n8, y8};
  endfunction

  function automatic logic [63:0] obs16();
    return {43'b0, ov16_v, c16, o16, z16, n16, y16};
  endfunction

  // Reference: signed values as plain integers, overflow = out of range.
  function automatic logic [63:0] model(int w, logic [63:0] a,
                                        logic [63:0] b, int op);
    logic [63:0] mask, y, s, m;
    longint half, full, sa, sb, sr, r;
    bit c, ov;
    int amt;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
    sa = (a >= 64'(half)) ? longint'(a) - full : longint'(a);
    sb = (b >= 64'(half)) ? longint'(b) - full : longint'(b);
    amt = (b >= 64'(w)) ? w - 1 : int'(b);
    c = 0; ov = 0; y = '0;
    case (op)
      0: begin
        s = a + b; y = s & mask; c = (s > mask);
        sr = sa + sb; ov = (sr < -half) || (sr >= half);
      end
      1: begin
        y = (a - b) & mask; c = (a < b);
        sr = sa - sb; ov = (sr < -half) || (sr >= half);
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = (a << amt) & mask;
      6: y = a >> amt;
      default: begin
        r = sa >>> amt; y = 64'(r) & mask;
      end
    endcase
    m = y;
    m[w] = y[w-1];
    m[w+1] = (y == 0);
    m[w+2] = ov;
    m[w+3] = c;
    m[w+4] = 1'b1;
    return m;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // apply at a falling edge, check at the next falling edge
  task automatic d8(string tag, logic [2:0] op, logic [7:0] a,
                    logic [7:0] b, logic [7:0] ey, logic [3:0] fl);
    v8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    e8 = {51'b0, 1'b1, fl, ey};
    chk(tag, obs8(), e8);
  endtask

  logic [7:0] sb [5] = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd9};
  logic [7:0] sll_e [5] = '{8'h01, 8'h02, 8'h80, 8'h80, 8'h80};
  logic [7:0] srl_e [5] = '{8'h80, 8'h40, 8'h01, 8'h01, 8'h01};
  logic [7:0] sra_e [5] = '{8'h80, 8'hC0, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    logic [7:0] ey;
    rst_n = 1'b0;
    v8 = 0; a8 = 0; b8 = 0; op8 = 0;
    v16 = 0; a16 = 0; b16 = 0; op16 = 0;
    repeat (2) @(negedge clk);
    chk("reset8", obs8(), 64'd0);
    chk("reset16", obs16(), 64'd0);
    rst_n = 1'b1;

    d8("add_ff_1", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010);
    d8("add_7f_1", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101);
    d8("sub_0_1", 3'd1, 8'h00, 8'h01, 8'hFF, 4'b1001);
    d8("sub_80_1", 3'd1, 8'h80, 8'h01, 8'h7F, 4'b0100);
    d8("sub_5_3", 3'd1, 8'h05, 8'h03, 8'h02, 4'b0000);
    d8("and", 3'd2, 8'hFF, 8'h00, 8'h00, 4'b0010);
    d8("or", 3'd3, 8'hFF, 8'h00, 8'hFF, 4'b0001);
    d8("xor", 3'd4, 8'hFF, 8'hFF, 8'h00, 4'b0010);

    for (int i = 0; i < 5; i++) begin
      ey = sll_e[i];
      d8($sformatf("sll_b%0d", sb[i]), 3'd5, 8'h01, sb[i],
         ey, {2'b00, ey == 8'h00, ey[7]});
      ey = srl_e[i];
      d8($sformatf("srl_b%0d", sb[i]), 3'd6, 8'h80, sb[i],
         ey, {2'b00, ey == 8'h00, ey[7]});
      ey = sra_e[i];
      d8($sformatf("sra_b%0d", sb[i]), 3'd7, 8'h80, sb[i],
         ey, {2'b00, ey == 8'h00, ey[7]});
      d8($sformatf("sra0_b%0d", sb[i]), 3'd7, 8'h00, sb[i],
         8'h00, 4'b0010);
    end
    d8("sra0_bff", 3'd7, 8'h00, 8'hFF, 8'h00, 4'b0010);
    d8("sll_bff", 3'd5, 8'h01, 8'hFF, 8'h80, 4'b0001);

    d8("pipe0", 3'd0, 8'h01, 8'h02, 8'h03, 4'b0000);
    d8("pipe1", 3'd1, 8'h03, 8'h03, 8'h00, 4'b0010);
    d8("pipe2", 3'd4, 8'h0F, 8'hF0, 8'hFF, 4'b0001);

    v8 = 1'b0; a8 = 8'h12; b8 = 8'h34; op8 = 3'd0;
    @(negedge clk);
    e8[12] = 1'b0;
    chk("hold0", obs8(), e8);
    a8 = 8'hFF; b8 = 8'hFF; op8 = 3'd1;
    @(negedge clk);
    chk("hold1", obs8(), e8);

    d8("pre_rst", 3'd0, 8'h10, 8'h20, 8'h30, 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs8(), 64'd0);
    @(negedge clk);
    chk("rst_hold", obs8(), 64'd0);
    v8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rel", obs8(), 64'd0);
    d8("first_valid", 3'd0, 8'h01, 8'h01, 8'h02, 4'b0000);

    e16 = '0;
    for (int i = 0; i < 600; i++) begin
      v8 = ($urandom % 5) != 0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      op8 = 3'($urandom % 8);
      if (op8 >= 3'd5 && ($urandom % 2) == 0) b8 = 8'($urandom % 11);
      v16 = ($urandom % 5) != 0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      op16 = 3'($urandom % 8);
      if (op16 >= 3'd5 && ($urandom % 2) == 0) b16 = 16'($urandom % 19);
      @(negedge clk);
      if (v8) e8 = model(8, 64'(a8), 64'(b8), int'(op8));
      else e8[12] = 1'b0;
      if (v16) e16 = model(16, 64'(a16), 64'(b16), int'(op16));
      else e16[20] = 1'b0;
      chk($sformatf("rnd8_%0d", i), obs8(), e8);
      chk($sformatf("rnd16_%0d", i), obs16(), e16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
